// File: rtl/tx_frame_mod.sv
// tx_frame_mod: transmit-side burst framer and QPSK mapper.
// A burst is preamble, a 16-bit length header, the payload bytes and
// trailing guard zeros. One QPSK symbol is emitted per DAC sample strobe.
module tx_frame_mod #(
  parameter int                 CLK_DIV   = 8,
  parameter int                 PRE_LEN   = 32,
  parameter int                 GUARD_LEN = 16,
  parameter logic signed [15:0] AMP       = 16'sd8192
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ctrl,
  input  logic [15:0] i_len,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_vld,
  output logic        o_byte_rdy,
  output logic [15:0] o_toDAC_i,
  output logic [15:0] o_toDAC_q,
  output logic        o_toDAC_vld,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_underflow
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_GUARD
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [DIV_W-1:0] r_divCnt;
  logic             w_strobe;

  logic             r_startPrev;
  logic             w_startAcc;

  logic [15:0]      r_len;
  logic [17:0]      r_symCnt;
  logic             w_payEnd;

  logic [7:0]       r_buf;
  logic             r_bufFull;
  logic [16:0]      r_fetchCnt;
  logic             w_xfer;

  logic [1:0]       w_hdrPair;
  logic [1:0]       w_payPair;

  logic [1:0]       w_pair;
  logic             w_zero;
  logic             w_cntClr;
  logic             w_cntInc;
  logic             w_consume;
  logic             w_underflowSet;
  logic             w_doneSet;

  logic [15:0]      r_dacI;
  logic [15:0]      r_dacQ;
  logic             r_dacVld;
  logic             r_done;
  logic             r_underflow;

  logic             w_unusedCtrl;

  // Control bits above start/enable are reserved and deliberately ignored.
  assign w_unusedCtrl = ^i_ctrl[31:2];

  assign w_strobe   = (r_divCnt == DIV_W'(CLK_DIV - 1));
  assign w_startAcc = i_ctrl[0] & ~r_startPrev & i_ctrl[1] & (r_state == S_IDLE);

  // Last payload symbol is index 4*len-1; PAY is only entered with len >= 1.
  assign w_payEnd = (r_symCnt == ({r_len, 2'b00} - 18'd1));

  // Header and payload are sent most-significant pair first.
  assign w_hdrPair = {r_len[{~r_symCnt[2:0], 1'b1}], r_len[{~r_symCnt[2:0], 1'b0}]};
  assign w_payPair = {r_buf[{~r_symCnt[1:0], 1'b1}], r_buf[{~r_symCnt[1:0], 1'b0}]};

  assign o_byte_rdy = ((r_state == S_HDR) || (r_state == S_PAY)) && !r_bufFull &&
                      (r_fetchCnt < {1'b0, r_len});
  assign w_xfer     = i_byte_vld & o_byte_rdy;

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_underflow = r_underflow;
  assign o_toDAC_i   = r_dacI;
  assign o_toDAC_q   = r_dacQ;
  assign o_toDAC_vld = r_dacVld;

  // Free-running sample strobe divider, independent of frame activity.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_divCnt <= '0;
    end else if (w_strobe) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // Previous start bit for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_startPrev <= 1'b0;
    end else begin
      r_startPrev <= i_ctrl[0];
    end
  end

  // Frame state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state, symbol selection and counter control; all changes happen on strobes except start.
  always_comb begin
    w_stateNext    = r_state;
    w_pair         = 2'b00;
    w_zero         = 1'b1;
    w_cntClr       = 1'b0;
    w_cntInc       = 1'b0;
    w_consume      = 1'b0;
    w_underflowSet = 1'b0;
    w_doneSet      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_startAcc) begin
          w_stateNext = S_PRE;
          w_cntClr    = 1'b1;
        end
      end
      S_PRE: begin
        if (w_strobe) begin
          w_zero = 1'b0;
          w_pair = r_symCnt[0] ? 2'b11 : 2'b00;
          if (r_symCnt == 18'(PRE_LEN - 1)) begin
            w_stateNext = S_HDR;
            w_cntClr    = 1'b1;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (w_strobe) begin
          w_zero = 1'b0;
          w_pair = w_hdrPair;
          if (r_symCnt[2:0] == 3'd7) begin
            w_stateNext = (r_len == 16'd0) ? S_GUARD : S_PAY;
            w_cntClr    = 1'b1;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      S_PAY: begin
        if (w_strobe) begin
          if (!r_bufFull) begin
            w_underflowSet = 1'b1;
            w_stateNext    = S_GUARD;
            w_cntClr       = 1'b1;
          end else begin
            w_zero = 1'b0;
            w_pair = w_payPair;
            if (r_symCnt[1:0] == 2'd3) begin
              w_consume = 1'b1;
            end
            if (w_payEnd) begin
              w_stateNext = S_GUARD;
              w_cntClr    = 1'b1;
            end else begin
              w_cntInc = 1'b1;
            end
          end
        end
      end
      S_GUARD: begin
        if (w_strobe) begin
          if (r_symCnt == 18'(GUARD_LEN - 1)) begin
            w_stateNext = S_IDLE;
            w_doneSet   = 1'b1;
            w_cntClr    = 1'b1;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Shared symbol counter, reused by every section of the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_symCnt <= '0;
    end else if (w_cntClr) begin
      r_symCnt <= '0;
    end else if (w_cntInc) begin
      r_symCnt <= r_symCnt + 18'd1;
    end
  end

  // Payload length is captured once per frame at start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len <= '0;
    end else if (w_startAcc) begin
      r_len <= i_len;
    end
  end

  // One-byte buffer; a new byte arriving wins over the emptying of the old one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf      <= '0;
      r_bufFull  <= 1'b0;
      r_fetchCnt <= '0;
    end else if (w_startAcc) begin
      r_bufFull  <= 1'b0;
      r_fetchCnt <= '0;
    end else if (w_xfer) begin
      r_buf      <= i_byte;
      r_bufFull  <= 1'b1;
      r_fetchCnt <= r_fetchCnt + 17'd1;
    end else if (w_consume) begin
      r_bufFull <= 1'b0;
    end
  end

  // DAC sample registers load on strobe together with the valid pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dacI   <= '0;
      r_dacQ   <= '0;
      r_dacVld <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_dacVld <= w_strobe;
      r_done   <= w_doneSet;
      if (w_strobe) begin
        r_dacI <= w_zero ? 16'sd0 : (w_pair[1] ? -AMP : AMP);
        r_dacQ <= w_zero ? 16'sd0 : (w_pair[0] ? -AMP : AMP);
      end
    end
  end

  // Sticky underflow flag, cleared by the next accepted start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_underflow <= 1'b0;
    end else if (w_startAcc) begin
      r_underflow <= 1'b0;
    end else if (w_underflowSet) begin
      r_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_frame_mod.sv
// tb_tx_frame_mod: self-checking bench for tx_frame_mod.
// Expected bursts are built from the frame rules (preamble, header, payload, guard).
module tb_tx_frame_mod;

  localparam int          CLK_DIV   = 8;
  localparam int          PRE_LEN   = 32;
  localparam int          GUARD_LEN = 16;
  localparam logic [15:0] POS       = 16'h2000;
  localparam logic [15:0] NEG       = 16'hE000;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ctrl;
  logic [15:0] i_len;
  logic [7:0]  i_byte;
  logic        i_byte_vld;
  logic        o_byte_rdy;
  logic [15:0] o_toDAC_i;
  logic [15:0] o_toDAC_q;
  logic        o_toDAC_vld;
  logic        o_busy;
  logic        o_done;
  logic        o_underflow;

  int total = 0;
  int bad = 0;
  int doneCnt = 0;
  int byteIdx = 0;
  int byteLimit = 0;
  logic [7:0]  txBytes [0:15];
  logic [15:0] expI [$];
  logic [15:0] expQ [$];

  tx_frame_mod #(
    .CLK_DIV(CLK_DIV),
    .PRE_LEN(PRE_LEN),
    .GUARD_LEN(GUARD_LEN),
    .AMP(16'sd8192)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_ctrl(i_ctrl),
    .i_len(i_len),
    .i_byte(i_byte),
    .i_byte_vld(i_byte_vld),
    .o_byte_rdy(o_byte_rdy),
    .o_toDAC_i(o_toDAC_i),
    .o_toDAC_q(o_toDAC_q),
    .o_toDAC_vld(o_toDAC_vld),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  // Count done pulses seen anywhere in the run.
  always @(negedge clk) begin
    if (o_done === 1'b1) doneCnt++;
  end

  // Byte source: offers txBytes[0..byteLimit-1]; a handshake is counted when rdy is seen with vld.
  initial begin
    i_byte = 8'h00;
    i_byte_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (byteIdx < byteLimit) begin
        i_byte = txBytes[byteIdx];
        i_byte_vld = 1'b1;
        if (o_byte_rdy === 1'b1) byteIdx++;
      end else begin
        i_byte = 8'h00;
        i_byte_vld = 1'b0;
      end
    end
  end

  function automatic void push_sym(input int p, input bit isZero);
    if (isZero) begin
      expI.push_back(16'h0000);
      expQ.push_back(16'h0000);
    end else begin
      expI.push_back(((p >> 1) & 1) != 0 ? NEG : POS);
      expQ.push_back((p & 1) != 0 ? NEG : POS);
    end
  endfunction

  // Reference burst: preamble, header, payload until bytes run out (one zero on underflow), guard.
  function automatic void build_expected(input int len, input int avail);
    expI.delete();
    expQ.delete();
    for (int k = 0; k < PRE_LEN; k++) push_sym((k % 2) ? 3 : 0, 1'b0);
    for (int k = 0; k < 8; k++) push_sym((len >> (14 - 2 * k)) & 3, 1'b0);
    for (int b = 0; b < len; b++) begin
      if (b >= avail) begin
        push_sym(0, 1'b1);
        break;
      end
      for (int k = 0; k < 4; k++) push_sym((int'(txBytes[b]) >> (6 - 2 * k)) & 3, 1'b0);
    end
    for (int k = 0; k < GUARD_LEN; k++) push_sym(0, 1'b1);
  endfunction

  task automatic wait_vld(input string tag, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3 * CLK_DIV && !ok; k++) begin
      @(negedge clk);
      if (o_toDAC_vld === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: vld_timeout got no strobe want strobe within %0d clocks", tag, 3 * CLK_DIV);
    end
  endtask

  // Runs one burst and compares every sample; midStart pulses a stray start, rstAt aborts with reset.
  task automatic run_frame(input int len, input int avail, input int midStart, input int rstAt,
                           input string name);
    bit ok;
    int startDone;
    int n;
    int expXfer;
    bit expUnder;
    build_expected(len, avail);
    expXfer = (avail < len) ? avail : len;
    expUnder = (avail < len);
    i_len = 16'(len);
    byteIdx = 0;
    byteLimit = avail;
    wait_vld({name, "/align"}, ok);
    i_ctrl = 32'h3;
    @(negedge clk);
    i_ctrl = 32'h2;
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s/busy_rise got %b want 1", name, o_busy);
    end
    total++;
    if (o_underflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s/underflow_clr got %b want 0", name, o_underflow);
    end
    startDone = doneCnt;
    n = expI.size();
    for (int s = 0; s < n; s++) begin
      wait_vld(name, ok);
      if (!ok) break;
      if (s == rstAt) begin
        i_rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_toDAC_vld, o_toDAC_i, o_toDAC_q, o_busy, o_done, o_underflow, o_byte_rdy} !== 38'd0) begin
          bad++;
          $display("[TB] FAIL %s/reset_outputs got vld=%b i=%h q=%h busy=%b done=%b uf=%b rdy=%b want all 0",
                   name, o_toDAC_vld, o_toDAC_i, o_toDAC_q, o_busy, o_done, o_underflow, o_byte_rdy);
        end
        i_rst = 1'b0;
        byteLimit = 0;
        return;
      end
      if (s == midStart) i_ctrl = 32'h3;
      else if (s == midStart + 1) i_ctrl = 32'h2;
      total++;
      if (o_toDAC_i !== expI[s] || o_toDAC_q !== expQ[s]) begin
        bad++;
        $display("[TB] FAIL %s/sample[%0d] got (%h,%h) want (%h,%h)", name, s, o_toDAC_i, o_toDAC_q,
                 expI[s], expQ[s]);
      end
    end
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s/frame_end got done=%b busy=%b want done=1 busy=0", name, o_done, o_busy);
    end
    total++;
    if (o_underflow !== expUnder) begin
      bad++;
      $display("[TB] FAIL %s/underflow got %b want %b", name, o_underflow, expUnder);
    end
    total++;
    if (byteIdx != expXfer) begin
      bad++;
      $display("[TB] FAIL %s/handshakes got %0d want %0d", name, byteIdx, expXfer);
    end
    wait_vld({name, "/after"}, ok);
    total++;
    if (o_toDAC_i !== 16'h0 || o_toDAC_q !== 16'h0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s/post_idle got (%h,%h) busy=%b want (0000,0000) busy=0", name, o_toDAC_i,
               o_toDAC_q, o_busy);
    end
    total++;
    if (doneCnt - startDone != 1) begin
      bad++;
      $display("[TB] FAIL %s/done_count got %0d want 1", name, doneCnt - startDone);
    end
  endtask

  task automatic test_reset();
    int vldCnt;
    int lastCyc;
    i_rst = 1'b1;
    i_ctrl = 32'h0;
    i_len = 16'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_toDAC_vld, o_toDAC_i, o_toDAC_q, o_busy, o_done, o_underflow, o_byte_rdy} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset/values got vld=%b i=%h q=%h busy=%b done=%b uf=%b rdy=%b want all 0",
               o_toDAC_vld, o_toDAC_i, o_toDAC_q, o_busy, o_done, o_underflow, o_byte_rdy);
    end
    i_rst = 1'b0;
    vldCnt = 0;
    lastCyc = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (o_toDAC_vld === 1'b1) begin
        vldCnt++;
        total++;
        if (cyc - lastCyc != CLK_DIV) begin
          bad++;
          $display("[TB] FAIL reset/strobe_spacing got %0d want %0d", cyc - lastCyc, CLK_DIV);
        end
        lastCyc = cyc;
        total++;
        if (o_toDAC_i !== 16'h0 || o_toDAC_q !== 16'h0) begin
          bad++;
          $display("[TB] FAIL reset/idle_sample got (%h,%h) want (0000,0000)", o_toDAC_i, o_toDAC_q);
        end
      end
      if (o_busy !== 1'b0 || o_byte_rdy !== 1'b0) begin
        total++;
        bad++;
        $display("[TB] FAIL reset/idle_flags got busy=%b rdy=%b want 0 0", o_busy, o_byte_rdy);
      end
    end
    total++;
    if (vldCnt != 100 / CLK_DIV) begin
      bad++;
      $display("[TB] FAIL reset/strobe_count got %0d want %0d", vldCnt, 100 / CLK_DIV);
    end
  endtask

  task automatic test_len2();
    txBytes[0] = 8'h1B;
    txBytes[1] = 8'hE4;
    run_frame(2, 2, -10, -1, "len2");
  endtask

  task automatic test_len0();
    run_frame(0, 0, -10, -1, "len0");
  endtask

  task automatic test_underflow();
    for (int b = 0; b < 4; b++) txBytes[b] = 8'($urandom);
    run_frame(4, 2, -10, -1, "underflow");
    repeat (20) @(negedge clk);
    total++;
    if (o_underflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL underflow/sticky got %b want 1", o_underflow);
    end
    txBytes[0] = 8'($urandom);
    run_frame(1, 1, -10, -1, "underflow_clear");
  endtask

  task automatic test_ignore();
    int d0;
    d0 = doneCnt;
    i_ctrl = 32'h1;
    repeat (20) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_toDAC_i !== 16'h0) begin
      bad++;
      $display("[TB] FAIL ignore/disabled_start got busy=%b i=%h want busy=0 i=0000", o_busy, o_toDAC_i);
    end
    i_ctrl = 32'h0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) txBytes[b] = 8'($urandom);
    run_frame(3, 3, 20, -1, "ignore_mid");
    repeat (2 * CLK_DIV * 4) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || doneCnt - d0 != 1) begin
      bad++;
      $display("[TB] FAIL ignore/no_second_frame got busy=%b dones=%0d want busy=0 dones=1", o_busy,
               doneCnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    for (int b = 0; b < 3; b++) txBytes[b] = 8'($urandom);
    d0 = doneCnt;
    run_frame(3, 3, -10, PRE_LEN + 8 + 5, "rst_mid");
    repeat (120) @(negedge clk);
    total++;
    if (doneCnt != d0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid/no_done got dones=%0d busy=%b want dones=0 busy=0", doneCnt - d0, o_busy);
    end
    for (int b = 0; b < 3; b++) txBytes[b] = 8'($urandom);
    run_frame(3, 3, -10, -1, "rst_mid_after");
  endtask

  task automatic test_random();
    int len;
    int avail;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 6);
      avail = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : len;
      for (int b = 0; b < len; b++) txBytes[b] = 8'($urandom);
      run_frame(len, avail, -10, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_len2();
    test_len0();
    test_underflow();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_mod.md
# tx_frame_mod

Transmit-side framer and QPSK mapper for the V2X radio datapath. It sits between the payload source (AXI/PS-fed byte stream) and the fmcomms DAC interface. On a start request it emits a burst of preamble, length header, payload and guard as QPSK symbols. Symbols go out at one per DAC sample strobe, and the burst matches what the `rx` chain acquires and demodulates.

## Interface
Parameters:
- `CLK_DIV`, 8: clocks per output sample strobe (32 MHz clock, 4 MS/s).
- `PRE_LEN`, 32: preamble length in symbols.
- `GUARD_LEN`, 16: trailing zero symbols.
- `AMP`, 16'sd8192: signed QPSK amplitude per rail.

Ports:
- `i_clk` in 1: sole clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_ctrl` in 32: bit0 start (rising-edge sensitive); bit1 enable; others reserved.
- `i_len` in 16: payload length in bytes; latched on accepted start.
- `i_byte` in 8: payload byte.
- `i_byte_vld` in 1: payload byte valid.
- `o_byte_rdy` out 1: block can accept a byte; a transfer occurs when `i_byte_vld` and `o_byte_rdy` are both high.
- `o_toDAC_i`, `o_toDAC_q` out 16: signed sample.
- `o_toDAC_vld` out 1: one-cycle strobe per sample.
- `o_busy` out 1: high while a frame is in progress.
- `o_done` out 1: one-cycle pulse at frame end.
- `o_underflow` out 1: sticky flag; cleared by reset or by the next accepted start.

## Operation
- Strobe counter runs free modulo `CLK_DIV` from reset. A strobe occurs when count == `CLK_DIV`-1. `o_toDAC_vld` pulses on every strobe, including in IDLE, where it carries zeros.
- Start is accepted when bit0 rises (registered edge detect), bit1 = 1, and the state is IDLE. Start while busy or disabled is ignored.
- State machine:
  - IDLE → PRE on accepted start.
  - PRE: `PRE_LEN` symbols alternating 2'b00, 2'b11, beginning with 00.
  - HDR: 8 symbols carrying `i_len`, MSB pair first.
  - PAY: 4·`i_len` symbols; each byte is sent MSB pair first. PAY is skipped when `i_len` = 0.
  - GUARD: `GUARD_LEN` zero samples, then `o_done` and IDLE.
- QPSK mapping of pair b1b0: I = b1 ? −AMP : +AMP; Q = b0 ? −AMP : +AMP. Zero symbols output exactly 0.
- Byte buffer is one byte deep.
  - `o_byte_rdy` is high in HDR and PAY whenever the buffer is empty and bytes remain to fetch.
  - The buffer empties on the strobe that emits the byte's fourth symbol.
  - A transfer and an emptying in the same cycle leave the buffer full with the new byte.
- Underflow: on a PAY strobe with the buffer empty, the block:
  - emits zero;
  - sets `o_underflow`;
  - drops the remaining payload and jumps to GUARD (full `GUARD_LEN`).
- Symbol and byte counters are sized for 4·65535 payload symbols; no wrap occurs within a frame.

## Timing
- Reset values: `o_toDAC_i`/`o_toDAC_q` = 0, `o_toDAC_vld` = 0, `o_byte_rdy` = 0, `o_busy` = 0, `o_done` = 0, `o_underflow` = 0. After reset: state IDLE, strobe counter 0.
- Start edge sampled at cycle t sets `o_busy` at t+1. The first preamble symbol appears on the first strobe after t+1.
- Output sample registers update in the same cycle that `o_toDAC_vld` is high and hold until the next strobe.
- `o_done` pulses in the cycle after the strobe carrying the last guard sample. `o_busy` falls in the same cycle, and a new start is accepted from the following cycle.
- Reset mid-frame abandons the frame immediately. No `o_done` is issued and the next strobe outputs zero.
- Frame duration is (`PRE_LEN` + 8 + 4·len + `GUARD_LEN`) strobes.

## Test plan
- Reset, idle 100 clocks → `o_toDAC_vld` pulses every 8 clocks with I = Q = 0; `o_busy` = 0; `o_byte_rdy` = 0.
- `i_len` = 2, bytes 0x1B, 0xE4 always valid, start → 64 strobes:
  - preamble (+8192,+8192), (−8192,−8192) alternating ×16;
  - header: 7× (+,+) then (−8192,+8192);
  - payload: (+,+), (+,−), (−,+), (−,−), (−,−), (−,+), (+,−), (+,+);
  - 16 zeros, then `o_done` pulse.
- `i_len` = 0 → 56 strobes: preamble, header all (+,+), guard. Zero byte handshakes.
- `i_len` = 4 with `i_byte_vld` dropped before byte 3 → byte 3 slot emits zero, `o_underflow` = 1, 16 guard zeros, `o_done`. The next start clears `o_underflow`.
- Second start edge mid-frame and start with enable = 0 → both ignored; frame length unchanged; no second frame.
- Assert `i_rst` during PAY → next cycle all outputs are at reset values; no `o_done`; a subsequent start produces a full correct frame.
